// File: rtl/memarb_pkg.sv
// Shared types for the memory-bus arbiter: sequencer states, requester IDs,
// the latched bus command and the round-robin pick helper.
package memarb_pkg;

  localparam int ICBEATS_DEF = 4;

  typedef enum logic [2:0] {
    MASTIDLE = 3'd0,
    MASTCMD  = 3'd1,
    MASTRD   = 3'd2,
    MASTWR   = 3'd3,
    MASTDONE = 3'd4
  } mast_state_e;

  typedef enum logic {
    ARBIC = 1'b0,
    ARBDC = 1'b1
  } arb_id_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [2:0]  sz;
  } bus_cmd_t;

  // Round robin: a lone request wins outright, a tie goes to the side
  // that did not own the bus last time.
  function automatic arb_id_e arb_pick(input logic icreq, input logic dcreq,
                                       input arb_id_e last);
    arb_id_e pick;
    if (icreq && dcreq) begin
      if (last == ARBIC) pick = ARBDC;
      else               pick = ARBIC;
    end else if (dcreq) begin
      pick = ARBDC;
    end else begin
      pick = ARBIC;
    end
    return pick;
  endfunction

endpackage

// File: rtl/memarb_bus_wdog.sv
// Bus watchdog: counts idle cycles of an active transaction and flags
// expiry once the count reaches TIMEOUT. Clear has priority over count.
module memarb_bus_wdog #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_r;

  assign expired = (cnt_r >= LIMIT);

  // Idle-cycle counter; saturates at the limit so expiry stays asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && !expired) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/memarb.sv
// Memory-bus arbiter between the I-cache line-fill path and the D-side
// (fill, writeback, uncached access). Grants one side, then sequences the
// command phase, the beat-counted data phase and a one-cycle completion.
module memarb
  import memarb_pkg::*;
#(
  parameter int ICBEATS = ICBEATS_DEF,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        icreq,
  input  logic [31:0] icaddr,
  output logic        icgnt,
  output logic        icrvalid,
  output logic        icdone,
  output logic        icerr,
  input  logic        dcreq,
  input  logic        dcwr,
  input  logic [31:0] dcaddr,
  input  logic [2:0]  dclen,
  input  logic [2:0]  dcsz,
  input  logic [63:0] dcwdata,
  output logic        dcgnt,
  output logic        dcwready,
  output logic        dcrvalid,
  output logic        dcdone,
  output logic        dcerr,
  output logic [63:0] rdata,
  output logic        memreq,
  output logic        memwr,
  output logic [31:0] memaddr,
  output logic [2:0]  memlen,
  output logic [2:0]  memsz,
  input  logic        memack,
  input  logic        memrvalid,
  input  logic [63:0] memrdata,
  input  logic        memwready,
  output logic [63:0] memwdata,
  input  logic        memerr
);

  mast_state_e state_r, state_s;
  arb_id_e     owner_r, last_r, pick_s;
  bus_cmd_t    cmd_r;
  logic        err_r;
  logic [2:0]  beat_r;
  logic        icrvalid_r, dcrvalid_r;
  logic [63:0] rdata_r;

  logic grant_s, ack_s, rbeat_s, wbeat_s, last_beat_s, timeout_s;
  logic expired_s, wd_clr_s, wd_en_s, active_s;

  // Qualified bus events: strobes only count in the state that expects them,
  // and an ack arriving after the command was withdrawn by timeout is ignored.
  assign pick_s      = arb_pick(icreq, dcreq, last_r);
  assign grant_s     = (state_r == MASTIDLE) && (icreq || dcreq);
  assign ack_s       = (state_r == MASTCMD) && !expired_s && memack;
  assign rbeat_s     = (state_r == MASTRD) && memrvalid;
  assign wbeat_s     = (state_r == MASTWR) && memwready;
  assign last_beat_s = (rbeat_s || wbeat_s) && (beat_r == cmd_r.len);
  assign active_s    = (state_r == MASTCMD) || (state_r == MASTRD) || (state_r == MASTWR);
  assign timeout_s   = active_s && expired_s && !ack_s && !rbeat_s && !wbeat_s;

  assign wd_clr_s = grant_s || ack_s || rbeat_s || wbeat_s;
  assign wd_en_s  = active_s;

  memarb_bus_wdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .expired (expired_s)
  );

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      MASTIDLE: begin
        if (grant_s) state_s = MASTCMD;
        else         state_s = MASTIDLE;
      end
      MASTCMD: begin
        if (timeout_s)  state_s = MASTDONE;
        else if (ack_s) state_s = cmd_r.wr ? MASTWR : MASTRD;
        else            state_s = MASTCMD;
      end
      MASTRD, MASTWR: begin
        if (last_beat_s || timeout_s) state_s = MASTDONE;
        else                          state_s = state_r;
      end
      MASTDONE: state_s = MASTIDLE;
      default:  state_s = MASTIDLE;
    endcase
  end

  // State, ownership and latched command; a new grant re-arms the error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= MASTIDLE;
      owner_r <= ARBIC;
      last_r  <= ARBIC;
      cmd_r   <= '0;
      err_r   <= 1'b0;
      beat_r  <= 3'd0;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        owner_r <= pick_s;
        last_r  <= pick_s;
        err_r   <= 1'b0;
        beat_r  <= 3'd0;
        if (pick_s == ARBIC) begin
          cmd_r.wr   <= 1'b0;
          cmd_r.addr <= icaddr;
          cmd_r.len  <= 3'(ICBEATS - 1);
          cmd_r.sz   <= 3'd7;
        end else begin
          cmd_r.wr   <= dcwr;
          cmd_r.addr <= dcaddr;
          cmd_r.len  <= dclen;
          cmd_r.sz   <= dcsz;
        end
      end else begin
        if (((ack_s || rbeat_s || wbeat_s) && memerr) || timeout_s) err_r <= 1'b1;
        else                                                        err_r <= err_r;
        if (rbeat_s || wbeat_s) beat_r <= beat_r + 3'd1;
        else                    beat_r <= beat_r;
      end
    end
  end

  // Read beats are re-timed by one cycle and steered to the owning side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      icrvalid_r <= 1'b0;
      dcrvalid_r <= 1'b0;
      rdata_r    <= 64'd0;
    end else begin
      icrvalid_r <= rbeat_s && (owner_r == ARBIC);
      dcrvalid_r <= rbeat_s && (owner_r == ARBDC);
      if (rbeat_s) rdata_r <= memrdata;
      else         rdata_r <= rdata_r;
    end
  end

  assign icgnt    = (state_r != MASTIDLE) && (owner_r == ARBIC);
  assign dcgnt    = (state_r != MASTIDLE) && (owner_r == ARBDC);
  assign icdone   = (state_r == MASTDONE) && (owner_r == ARBIC);
  assign dcdone   = (state_r == MASTDONE) && (owner_r == ARBDC);
  assign icerr    = icdone && err_r;
  assign dcerr    = dcdone && err_r;
  assign icrvalid = icrvalid_r;
  assign dcrvalid = dcrvalid_r;
  assign rdata    = rdata_r;

  assign memreq   = (state_r == MASTCMD) && !expired_s;
  assign memwr    = memreq && cmd_r.wr;
  assign memaddr  = memreq ? cmd_r.addr : 32'd0;
  assign memlen   = memreq ? cmd_r.len  : 3'd0;
  assign memsz    = memreq ? cmd_r.sz   : 3'd0;
  assign dcwready = wbeat_s;
  assign memwdata = (state_r == MASTWR) ? dcwdata : 64'd0;

endmodule

// File: tb/tb_memarb.sv
// Self-checking bench for memarb: table of transactions replayed through a
// bus-side responder, read beats scoreboarded, plus hand-written sequences
// for arbitration order, timeout and mid-transaction reset.
module tb_memarb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        icreq, dcreq, dcwr, memack, memrvalid, memwready, memerr;
  logic [31:0] icaddr, dcaddr;
  logic [2:0]  dclen, dcsz;
  logic [63:0] dcwdata, memrdata;
  logic        icgnt, icrvalid, icdone, icerr;
  logic        dcgnt, dcwready, dcrvalid, dcdone, dcerr;
  logic [63:0] rdata, memwdata;
  logic        memreq, memwr;
  logic [31:0] memaddr;
  logic [2:0]  memlen, memsz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ic;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [2:0]  sz;
    int          ackdly;
    int          errbeat;
    logic [63:0] dbase;
    logic [2:0]  exp_len;
    logic [2:0]  exp_sz;
    logic        exp_err;
  } txn_t;

  typedef struct packed {
    logic        ic;
    logic [63:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  txn_t tbl[6];

  memarb dut (
    .clk(clk), .reset_n(reset_n),
    .icreq(icreq), .icaddr(icaddr), .icgnt(icgnt), .icrvalid(icrvalid),
    .icdone(icdone), .icerr(icerr),
    .dcreq(dcreq), .dcwr(dcwr), .dcaddr(dcaddr), .dclen(dclen), .dcsz(dcsz),
    .dcwdata(dcwdata), .dcgnt(dcgnt), .dcwready(dcwready), .dcrvalid(dcrvalid),
    .dcdone(dcdone), .dcerr(dcerr), .rdata(rdata),
    .memreq(memreq), .memwr(memwr), .memaddr(memaddr), .memlen(memlen),
    .memsz(memsz), .memack(memack), .memrvalid(memrvalid), .memrdata(memrdata),
    .memwready(memwready), .memwdata(memwdata), .memerr(memerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic ic, input logic wr, input logic [31:0] addr,
                              input logic [2:0] len, input logic [2:0] sz, input int ackdly,
                              input int errbeat, input logic [63:0] dbase,
                              input logic [2:0] exp_len, input logic [2:0] exp_sz,
                              input logic exp_err);
    txn_t t;
    t.ic = ic; t.wr = wr; t.addr = addr; t.len = len; t.sz = sz;
    t.ackdly = ackdly; t.errbeat = errbeat; t.dbase = dbase;
    t.exp_len = exp_len; t.exp_sz = exp_sz; t.exp_err = exp_err;
    return t;
  endfunction

  // Read-beat scoreboard: every rvalid must match the oldest beat sent.
  always @(negedge clk) begin
    if (icrvalid || dcrvalid) begin
      if (sbq.size() == 0) begin
        chk("stray_rvalid", {62'd0, icrvalid, dcrvalid}, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rvalid_side", {62'd0, icrvalid, dcrvalid}, {62'd0, mon_e.ic, !mon_e.ic});
        chk("rdata", rdata, mon_e.data);
      end
    end
  end

  task automatic drive_req(input txn_t t);
    if (t.ic) begin
      icreq = 1'b1; icaddr = t.addr;
    end else begin
      dcreq = 1'b1; dcaddr = t.addr; dcwr = t.wr; dclen = t.len; dcsz = t.sz;
    end
  endtask

  task automatic drop_req(input txn_t t);
    if (t.ic) icreq = 1'b0;
    else      dcreq = 1'b0;
  endtask

  task automatic wait_gnt(input logic ic);
    int n;
    n = 0;
    @(negedge clk);
    while (!(ic ? icgnt : dcgnt) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_wait", {63'd0, (ic ? icgnt : dcgnt)}, 64'd1);
  endtask

  // Called at the negedge of the first CMD cycle; plays the bus side.
  task automatic serve(input txn_t t);
    logic [63:0] d;
    chk("cmd_memreq", {63'd0, memreq}, 64'd1);
    chk("cmd_memwr", {63'd0, memwr}, {63'd0, t.wr});
    chk("cmd_memaddr", {32'd0, memaddr}, {32'd0, t.addr});
    chk("cmd_memlen", {61'd0, memlen}, {61'd0, t.exp_len});
    chk("cmd_memsz", {61'd0, memsz}, {61'd0, t.exp_sz});
    for (int i = 0; i < t.ackdly; i++) begin
      @(posedge clk); #1;
      drop_req(t);
      @(negedge clk);
      chk("cmd_hold", {63'd0, memreq}, 64'd1);
    end
    @(posedge clk); #1;
    drop_req(t);
    memack = 1'b1;
    @(negedge clk);
    chk("cmd_ackcyc", {63'd0, memreq}, 64'd1);
    @(posedge clk); #1;
    memack = 1'b0;
    for (int b = 0; b <= int'(t.exp_len); b++) begin
      d = t.dbase + 64'(b);
      memerr = (b == t.errbeat);
      if (t.wr) begin
        memwready = 1'b1;
        dcwdata = d;
        @(negedge clk);
        chk("dcwready", {63'd0, dcwready}, 64'd1);
        chk("memwdata", memwdata, d);
      end else begin
        memrvalid = 1'b1;
        memrdata = d;
        sbq.push_back('{ic: t.ic, data: d});
        @(negedge clk);
        chk("no_wready", {63'd0, dcwready}, 64'd0);
      end
      @(posedge clk); #1;
    end
    memrvalid = 1'b0; memwready = 1'b0; memerr = 1'b0; dcwdata = 64'd0;
    @(negedge clk);
    chk("done", {62'd0, icdone, dcdone}, {62'd0, t.ic, !t.ic});
    chk("err", {62'd0, icerr, dcerr}, {62'd0, t.ic && t.exp_err, !t.ic && t.exp_err});
    chk("gnt_in_done", {62'd0, icgnt, dcgnt}, {62'd0, t.ic, !t.ic});
    @(negedge clk);
    chk("idle_after", {60'd0, icgnt, dcgnt, icdone, dcdone}, 64'd0);
  endtask

  task automatic run_txn(input txn_t t);
    @(posedge clk); #1;
    drive_req(t);
    wait_gnt(t.ic);
    serve(t);
  endtask

  initial begin
    int n;
    txn_t ta, tb;
    reset_n = 1'b0;
    icreq = 1'b0; dcreq = 1'b0; dcwr = 1'b0; memack = 1'b0; memrvalid = 1'b0;
    memwready = 1'b0; memerr = 1'b0; icaddr = 32'd0; dcaddr = 32'd0;
    dclen = 3'd0; dcsz = 3'd0; dcwdata = 64'd0; memrdata = 64'd0;

    tbl[0] = mk(1'b1, 1'b0, 32'h0000_1000, 3'd0, 3'd0, 2, -1, 64'hA0, 3'd3, 3'd7, 1'b0);
    tbl[1] = mk(1'b0, 1'b0, 32'h0000_2000, 3'd1, 3'd7, 1, 1, 64'h11, 3'd1, 3'd7, 1'b1);
    tbl[2] = mk(1'b0, 1'b1, 32'h0000_3004, 3'd0, 3'd3, 0, -1, 64'hDEAD_BEEF, 3'd0, 3'd3, 1'b0);
    tbl[3] = mk(1'b0, 1'b1, 32'h0000_4000, 3'd3, 3'd7, 0, -1, 64'h5500_0000_0000_0000, 3'd3, 3'd7, 1'b0);
    tbl[4] = mk(1'b0, 1'b0, 32'h0000_5002, 3'd0, 3'd1, 1, -1, 64'h1234, 3'd0, 3'd1, 1'b0);
    tbl[5] = mk(1'b0, 1'b1, 32'h0000_6000, 3'd1, 3'd7, 3, 0, 64'h77, 3'd1, 3'd7, 1'b1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {52'd0, icgnt, icrvalid, icdone, icerr, dcgnt, dcwready,
                      dcrvalid, dcdone, dcerr, memreq, memwr, 1'b0},
        64'd0);
    chk("reset_bus", {memaddr, 26'd0, memlen, memsz}, 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // First tie after reset goes to the D side; I side follows after IDLE.
    ta = mk(1'b0, 1'b0, 32'h0000_8000, 3'd0, 3'd3, 0, -1, 64'h42, 3'd0, 3'd3, 1'b0);
    tb = mk(1'b1, 1'b0, 32'h0000_7000, 3'd0, 3'd0, 0, -1, 64'hC0, 3'd3, 3'd7, 1'b0);
    @(posedge clk); #1;
    drive_req(ta);
    drive_req(tb);
    wait_gnt(1'b0);
    chk("tie_ic_wait", {63'd0, icgnt}, 64'd0);
    serve(ta);
    @(negedge clk);
    chk("ic_after_idle", {63'd0, icgnt}, 64'd1);
    serve(tb);

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Timeout: no ack, command withdrawn after TIMEOUT cycles.
    @(posedge clk); #1;
    icreq = 1'b1; icaddr = 32'h0000_9000;
    wait_gnt(1'b1);
    @(posedge clk); #1;
    icreq = 1'b0;
    n = 1;
    @(negedge clk);
    while (memreq && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", 64'(n), 64'd255);
    @(negedge clk);
    chk("timeout_done", {62'd0, icdone, icerr}, 64'd3);
    @(negedge clk);
    chk("timeout_idle", {61'd0, icgnt, dcgnt, memreq}, 64'd0);

    // Late strobes while IDLE must not do anything.
    @(posedge clk); #1;
    memack = 1'b1; memrvalid = 1'b1; memrdata = 64'hBAD0; memwready = 1'b1;
    @(negedge clk);
    chk("idle_strobes", {60'd0, icgnt, dcgnt, memreq, dcwready}, 64'd0);
    @(posedge clk); #1;
    memack = 1'b0; memrvalid = 1'b0; memwready = 1'b0;
    @(negedge clk);
    chk("idle_no_rvalid", {62'd0, icrvalid, dcrvalid}, 64'd0);

    // Reset in the middle of a 4-beat I-side fill, after beat 2.
    @(posedge clk); #1;
    icreq = 1'b1; icaddr = 32'h0000_A000;
    wait_gnt(1'b1);
    @(posedge clk); #1;
    icreq = 1'b0; memack = 1'b1;
    @(posedge clk); #1;
    memack = 1'b0; memrvalid = 1'b1; memrdata = 64'hB0;
    sbq.push_back('{ic: 1'b1, data: 64'hB0});
    @(posedge clk); #1;
    memrdata = 64'hB1;
    sbq.push_back('{ic: 1'b1, data: 64'hB1});
    @(posedge clk); #1;
    memrvalid = 1'b0;
    @(negedge clk);
    chk("mid_gnt", {63'd0, icgnt}, 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_async", {61'd0, memreq, icgnt, icdone}, 64'd0);
    @(negedge clk);
    chk("rst_hold", {60'd0, memreq, icgnt, icdone, icrvalid}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    memrvalid = 1'b1; memrdata = 64'hBAD1;
    @(posedge clk); #1;
    memrvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", {62'd0, icrvalid, dcrvalid}, 64'd0);
    chk("post_rst_rdata", rdata, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {61'd0, icdone, icgnt, memreq}, 64'd0);
    end

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
